// File: rtl/cv32e40x_pkg.sv
// Shared types and constants for the prefetch controller slice.
package cv32e40x_pkg;

   typedef enum logic {
      IDLE        = 1'b0,
      BRANCH_WAIT = 1'b1
   } prefetch_state_e;

   localparam logic [31:0] PREFETCH_ADDR_INCR  = 32'd4;
   localparam int          PREFETCH_DROP_CNT_W = 16;

endpackage

// File: rtl/cv32e40x_prefetch_txn_counter.sv
// Outstanding-transaction counter and flush counter for the prefetch controller.
// drop_o marks a response that belongs to an abandoned stream.
module cv32e40x_prefetch_txn_counter #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_i,
   input  logic             dec_i,
   input  logic             load_i,
   output logic [CNT_W-1:0] out_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o,
   output logic             drop_o
);

   logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      out_cnt_d = out_cnt_q;
      if (inc_i && !dec_i)
         out_cnt_d = out_cnt_q + CNT_W'(1);
      else if (dec_i && !inc_i)
         out_cnt_d = out_cnt_q - CNT_W'(1);
   end

   // An accept in the branch cycle is new-stream work, so only old out_cnt_q is loaded.
   always_comb begin
      flush_cnt_d = flush_cnt_q;
      if (load_i)
         flush_cnt_d = out_cnt_q - CNT_W'(dec_i);
      else if (dec_i && flush_cnt_q != '0)
         flush_cnt_d = flush_cnt_q - CNT_W'(1);
   end

   assign drop_o = dec_i && (load_i || flush_cnt_q != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_cnt_q   <= '0;
         flush_cnt_q <= '0;
      end else begin
         out_cnt_q   <= out_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign out_cnt_o   = out_cnt_q;
   assign flush_cnt_o = flush_cnt_q;

endmodule

// File: rtl/cv32e40x_prefetch_controller.sv
// Prefetch fetch-address sequencer with FIFO/outstanding throttling and branch flush.
// Optional dropped-response counter built when CV32E40X_PREFETCH_PERF_EN is defined.
module cv32e40x_prefetch_controller
   import cv32e40x_pkg::*;
#(
   parameter int DEPTH           = 2,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           fetch_enable_i,
   input  logic                           branch_i,
   input  logic [31:0]                    branch_addr_i,
   input  logic [$clog2(DEPTH+1)-1:0]     fifo_cnt_i,
   output logic                           trans_valid_o,
   input  logic                           trans_ready_i,
   output logic [31:0]                    trans_addr_o,
   input  logic                           resp_valid_i,
   output logic                           fifo_push_o,
   output logic                           fifo_flush_o,
   output logic                           one_txn_pend_n_o,
   output logic                           busy_o,
   output logic [PREFETCH_DROP_CNT_W-1:0] flush_drop_cnt_o
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING+1);

   prefetch_state_e  state_q, state_d;
   logic [31:0]      addr_q, addr_d, branch_tgt;
   logic [CNT_W-1:0] out_cnt_q, flush_cnt_q;
   logic             accept, ok, below_max, drop;

   assign branch_tgt = branch_addr_i & ~32'h3;
   assign below_max  = int'(out_cnt_q) < MAX_OUTSTANDING;
   assign ok         = (int'(out_cnt_q) - int'(flush_cnt_q) + int'(fifo_cnt_i)) < DEPTH
                       && below_max;
   assign accept     = trans_valid_o && trans_ready_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      if (branch_i) begin
         addr_d  = accept ? branch_tgt + PREFETCH_ADDR_INCR : branch_tgt;
         state_d = accept ? IDLE : BRANCH_WAIT;
      end else if (accept) begin
         addr_d  = addr_q + PREFETCH_ADDR_INCR;
         state_d = IDLE;
      end
   end

   // While waiting on a redirect the FIFO has already been flushed, so occupancy is ignored.
   always_comb begin
      trans_valid_o = 1'b0;
      case (state_q)
         IDLE:        trans_valid_o = fetch_enable_i && ok;
         BRANCH_WAIT: trans_valid_o = fetch_enable_i && below_max;
         default:     trans_valid_o = 1'b0;
      endcase
      trans_addr_o = branch_i ? branch_tgt : addr_q;
   end

   cv32e40x_prefetch_txn_counter #(.CNT_W(CNT_W)) txn_counter_i (
      .clk         (clk),
      .rst_n       (rst_n),
      .inc_i       (accept),
      .dec_i       (resp_valid_i),
      .load_i      (branch_i),
      .out_cnt_o   (out_cnt_q),
      .flush_cnt_o (flush_cnt_q),
      .drop_o      (drop)
   );

   assign fifo_push_o      = resp_valid_i && !drop;
   assign fifo_flush_o     = branch_i;
   assign one_txn_pend_n_o = (out_cnt_q == '0);
   assign busy_o           = (out_cnt_q != '0) || (state_q == BRANCH_WAIT);

`ifdef CV32E40X_PREFETCH_PERF_EN
   logic [PREFETCH_DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop && drop_cnt_q != '1)
         drop_cnt_d = drop_cnt_q + PREFETCH_DROP_CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) drop_cnt_q <= '0;
      else        drop_cnt_q <= drop_cnt_d;
   end

   assign flush_drop_cnt_o = drop_cnt_q;
`else
   assign flush_drop_cnt_o = '0;
`endif

   a_out_max:   assert property (@(posedge clk) disable iff (!rst_n)
                                 int'(out_cnt_q) <= MAX_OUTSTANDING);
   a_flush_le:  assert property (@(posedge clk) disable iff (!rst_n)
                                 flush_cnt_q <= out_cnt_q);
   a_resp_pend: assert property (@(posedge clk) disable iff (!rst_n)
                                 !(resp_valid_i && out_cnt_q == '0));
   a_addr_algn: assert property (@(posedge clk) disable iff (!rst_n)
                                 trans_addr_o[1:0] == 2'b00);

endmodule

// File: tb/tb_cv32e40x_prefetch_controller.sv
// Directed + random bench for the prefetch controller against a queue-based model.
module tb_cv32e40x_prefetch_controller;
   localparam int DEPTH = 2;
   localparam int MAXO  = 2;
   localparam int CW    = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          fetch_enable_i = 1'b0, branch_i = 1'b0, trans_ready_i = 1'b0, resp_valid_i = 1'b0;
   logic [31:0]   branch_addr_i = '0;
   logic [CW-1:0] fifo_cnt_i = '0;
   logic          trans_valid_o, fifo_push_o, fifo_flush_o, one_txn_pend_n_o, busy_o;
   logic [31:0]   trans_addr_o;
   logic [15:0]   flush_drop_cnt_o;

   int errors = 0;
   int checks = 0;

   // Model: one entry per outstanding transaction, 1 = belongs to an abandoned stream.
   bit          q_stale[$];
   bit          m_wait;
   logic [31:0] m_addr;
   int          m_drops;

   always #5 clk = ~clk;

   cv32e40x_prefetch_controller #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
      .clk(clk), .rst_n(rst_n), .fetch_enable_i(fetch_enable_i), .branch_i(branch_i),
      .branch_addr_i(branch_addr_i), .fifo_cnt_i(fifo_cnt_i), .trans_valid_o(trans_valid_o),
      .trans_ready_i(trans_ready_i), .trans_addr_o(trans_addr_o), .resp_valid_i(resp_valid_i),
      .fifo_push_o(fifo_push_o), .fifo_flush_o(fifo_flush_o),
      .one_txn_pend_n_o(one_txn_pend_n_o), .busy_o(busy_o), .flush_drop_cnt_o(flush_drop_cnt_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q_stale.delete();
      m_wait  = 1'b0;
      m_addr  = '0;
      m_drops = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      fetch_enable_i = 0; branch_i = 0; trans_ready_i = 0; resp_valid_i = 0;
      branch_addr_i = '0; fifo_cnt_i = '0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One cycle: drive at negedge, check outputs against the model, advance the model.
   task automatic step(input bit fe, input bit br, input logic [31:0] ba,
                       input int fc, input bit rdy, input bit rv);
      int nstale, nonstale;
      bit e_valid, e_push, acc;
      logic [31:0] tgt, e_addr;
      @(negedge clk);
      fetch_enable_i = fe; branch_i = br; branch_addr_i = ba;
      fifo_cnt_i = CW'(fc); trans_ready_i = rdy; resp_valid_i = rv;
      #1;
      nstale = 0;
      foreach (q_stale[i]) nstale += int'(q_stale[i]);
      nonstale = q_stale.size() - nstale;
      tgt = {ba[31:2], 2'b00};
      if (m_wait) e_valid = fe && (q_stale.size() < MAXO);
      else        e_valid = fe && (nonstale + fc < DEPTH) && (q_stale.size() < MAXO);
      e_addr = br ? tgt : m_addr;
      e_push = rv && !br && (q_stale.size() > 0) && !q_stale[0];
      chk("trans_valid", 32'(trans_valid_o), 32'(e_valid));
      if (e_valid) chk("trans_addr", trans_addr_o, e_addr);
      chk("fifo_flush", 32'(fifo_flush_o), 32'(br));
      chk("fifo_push", 32'(fifo_push_o), 32'(e_push));
      chk("one_txn_pend_n", 32'(one_txn_pend_n_o), 32'(q_stale.size() == 0));
      chk("busy", 32'(busy_o), 32'((q_stale.size() != 0) || m_wait));
`ifdef CV32E40X_PREFETCH_PERF_EN
      chk("drop_cnt", 32'(flush_drop_cnt_o), 32'(m_drops > 65535 ? 65535 : m_drops));
`else
      chk("drop_cnt", 32'(flush_drop_cnt_o), 32'd0);
`endif
      acc = e_valid && rdy;
      if (rv && q_stale.size() > 0) begin
         void'(q_stale.pop_front());
         if (!e_push) m_drops++;
      end
      if (br) foreach (q_stale[i]) q_stale[i] = 1'b1;
      if (acc) q_stale.push_back(1'b0);
      if (br) begin
         m_addr = acc ? tgt + 32'd4 : tgt;
         m_wait = !acc;
      end else if (acc) begin
         m_addr = m_addr + 32'd4;
         m_wait = 1'b0;
      end
   endtask

   initial begin
      bit rv_r;
      do_reset();
      // Reset state with idle inputs
      step(0, 0, 0, 0, 0, 0);
      chk("rst_valid", 32'(trans_valid_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_pend_n", 32'(one_txn_pend_n_o), 32'd1);
      chk("rst_drop", 32'(flush_drop_cnt_o), 32'd0);
      // Branch with zero-cycle redirect, then sequential
      step(1, 1, 32'h8000_0002, 0, 1, 0);
      chk("br_addr", trans_addr_o, 32'h8000_0000);
      step(1, 0, 0, 0, 1, 0);
      chk("seq_addr", trans_addr_o, 32'h8000_0004);
      step(1, 0, 0, 0, 1, 0);
      chk("max_out", 32'(trans_valid_o), 32'd0);
      step(1, 0, 0, 0, 1, 1);
      // FIFO nearly full with one outstanding
      step(1, 0, 0, DEPTH-1, 1, 0);
      chk("fifo_throttle", 32'(trans_valid_o), 32'd0);
      step(1, 0, 0, 0, 1, 0);
      chk("fifo_release", trans_addr_o, 32'h8000_0008);
      // Branch with two outstanding, not accepted for three cycles
      step(1, 1, 32'h100, 0, 0, 0);
      chk("br_flush", 32'(fifo_flush_o), 32'd1);
      step(1, 0, 0, 0, 0, 0);
      chk("bw_busy", 32'(busy_o), 32'd1);
      chk("bw_addr", trans_addr_o, 32'h100);
      step(1, 0, 0, 0, 0, 1);
      chk("stale_drop0", 32'(fifo_push_o), 32'd0);
      step(1, 0, 0, 0, 1, 1);
      chk("stale_drop1", 32'(fifo_push_o), 32'd0);
      chk("bw_accept_addr", trans_addr_o, 32'h100);
      step(1, 0, 0, 0, 0, 1);
      chk("new_push", 32'(fifo_push_o), 32'd1);
      step(1, 0, 0, 0, 0, 0);
      chk("after_bw_addr", trans_addr_o, 32'h104);
`ifdef CV32E40X_PREFETCH_PERF_EN
      chk("perf_two", 32'(flush_drop_cnt_o), 32'd2);
`endif
      // Address wrap
      step(1, 1, 32'hFFFF_FFFC, 0, 1, 0);
      step(1, 0, 0, 0, 1, 0);
      chk("wrap_addr", trans_addr_o, 32'h0);
      // Branch coincident with response and accept
      step(1, 0, 0, 0, 0, 1);
      step(1, 1, 32'h200, 0, 1, 1);
      chk("coinc_drop", 32'(fifo_push_o), 32'd0);
      chk("coinc_accept", 32'(trans_valid_o), 32'd1);
      step(1, 0, 0, 0, 0, 1);
      chk("coinc_new_push", 32'(fifo_push_o), 32'd1);
      // Random phase, with one mid-run reset
      for (int n = 0; n < 3000; n++) begin
         if (n == 1500) do_reset();
         rv_r = (q_stale.size() > 0) && ($urandom_range(0, 1) == 1);
         step($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0, $urandom,
              int'($urandom_range(0, DEPTH)), $urandom_range(0, 1) == 1, rv_r);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
